// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro used by the top level: DMEM_PERF_CNT_EN.
package dmem_pkg;

  // Access size/sign, RISC-V funct3 encoding; unlisted codes behave as word
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int MAX_WAIT_STATES = 15;

endpackage

// File: rtl/dmem_if.sv
// Mem-stage bus between the core (master) and the data memory (slave).
interface dmem_if;

  logic [31:0] mem_addr_mem;
  logic [31:0] mem_wdata_mem;
  logic        mem_write_mem;
  logic        mem_read_mem;
  logic [2:0]  mem_op_mem;
  logic [31:0] mem_rdata_mem;
  logic        stall_pipl;
  logic        misaligned_err;

  modport master (
    output mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
    input  mem_rdata_mem, stall_pipl, misaligned_err
  );

  modport slave (
    input  mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
    output mem_rdata_mem, stall_pipl, misaligned_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane-replicated
// write word, load extraction with sign/zero extension, misalignment flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = 8'(rword_i >> {addr_i, 3'b000});
  assign sel_half = addr_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Decode size/sign; a misaligned access writes nothing and loads zero
  always_comb begin
    be_o         = 4'b1111;
    wword_o      = wdata_i;
    rdata_o      = rword_i;
    misaligned_o = 1'b0;
    case (op_i)
      MEM_B, MEM_BU: begin
        be_o    = 4'b0001 << addr_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = (op_i == MEM_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'b0, sel_byte};
      end
      MEM_H, MEM_HU: begin
        misaligned_o = addr_i[0];
        be_o         = addr_i[1] ? 4'b1100 : 4'b0011;
        wword_o      = {2{wdata_i[15:0]}};
        rdata_o      = (op_i == MEM_H) ? {{16{sel_half[15]}}, sel_half} : {16'b0, sel_half};
      end
      default: begin
        misaligned_o = (addr_i != 2'b00);
      end
    endcase
    if (misaligned_o) begin
      be_o    = 4'b0000;
      rdata_o = 32'b0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM, word SRAM with byte enables,
// registered load data. Define DMEM_PERF_CNT_EN to add rd_cnt/wr_cnt.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DMEM_DEPTH  = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int AW = $clog2(DMEM_DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > MAX_WAIT_STATES) ?
                                   4'(MAX_WAIT_STATES) : 4'(WAIT_STATES);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req, is_write, commit, stall;
  logic [AW-1:0] word_idx;
  logic [31:0] ram_rd_q, rdata_q;
  logic        mis_q;
  logic [3:0]  be;
  logic [31:0] wword, ld_data;
  logic        misaligned;
  logic        unused_addr_bits;

  logic [31:0] mem_q [DMEM_DEPTH];

  assign req              = bus.mem_read_mem | bus.mem_write_mem;
  assign is_write         = bus.mem_write_mem;
  assign word_idx         = bus.mem_addr_mem[AW+1:2];
  assign unused_addr_bits = ^bus.mem_addr_mem[31:AW+2];

  dmem_lane_align u_align (
    .addr_i       (bus.mem_addr_mem[1:0]),
    .op_i         (bus.mem_op_mem),
    .wdata_i      (bus.mem_wdata_mem),
    .rword_i      (ram_rd_q),
    .be_o         (be),
    .wword_o      (wword),
    .rdata_o      (ld_data),
    .misaligned_o (misaligned)
  );

  // State and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, stall and the commit strobe on the WAIT->DONE edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          state_d = WAIT;
          cnt_d   = WS_LOAD;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Array: read every cycle (address is stable throughout WAIT), byte-masked write on commit
  always_ff @(posedge clk) begin
    ram_rd_q <= mem_q[word_idx];
    if (!reset && commit && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Load data register and misalignment pulse, both valid in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'b0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= commit & misaligned;
      if (commit && !is_write) rdata_q <= ld_data;
    end
  end

  assign bus.stall_pipl     = stall;
  assign bus.mem_rdata_mem  = rdata_q;
  assign bus.misaligned_err = mis_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Completed, aligned access counters; visible from the DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 32'b0;
      wr_cnt_q <= 32'b0;
    end else if (commit && !misaligned) begin
      if (is_write) wr_cnt_q <= wr_cnt_q + 32'd1;
      else          rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the core's mem-stage bus.
- Accepts load/store requests from the core's mem stage and stores data in an internal word-organised SRAM.
- Performs byte/half/word lane alignment and load sign/zero extension.
- Holds the pipeline with stall_pipl for a configurable number of wait states, so slow memory can be modelled in the SoC.

Parameters:
- DMEM_DEPTH, 1024, number of 32-bit words in the array.
- WAIT_STATES, 1, extra wait cycles per access (0..15).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- mem_addr_mem  input  32  byte address from the core's mem stage
- mem_wdata_mem  input  32  store data, right-aligned
- mem_write_mem  input  1  store request
- mem_read_mem  input  1  load request
- mem_op_mem  input  3  access size/sign, RISC-V funct3 encoding
- mem_rdata_mem  output  32  aligned, extended load data
- stall_pipl  output  1  hold the pipeline while an access is in progress
- misaligned_err  output  1  one-cycle pulse on a misaligned access

Behaviour:
- Clocking: one clock (clk); synchronous active-high reset (reset).
- Request: req = mem_read_mem | mem_write_mem. If both are asserted, the write takes precedence.
- Core contract: the core holds the request stable while stall_pipl = 1.
- FSM states: IDLE, WAIT, DONE.
  - IDLE & req -> WAIT; cnt <= WAIT_STATES.
  - WAIT & cnt != 0 -> WAIT; cnt <= cnt - 1.
  - WAIT & cnt == 0 -> DONE. The array access happens on this edge: the store commits, or load data is captured into the rdata register.
  - DONE -> IDLE, unconditionally.
- stall_pipl is combinational: 1 when (IDLE & req) or in WAIT; 0 in DONE and in IDLE with no request.
- Latency: WAIT_STATES+2 stall cycles, then one DONE cycle in which the core advances.
  - A request still present in IDLE after DONE is treated as a new access; a repeated store is idempotent.
- mem_op encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Other codes behave as W.
- Word index = addr[$clog2(DMEM_DEPTH)+1:2]; upper address bits are ignored, so addresses wrap/alias.
- Stores:
  - SB writes byte lane addr[1:0] from wdata[7:0].
  - SH writes lane pair addr[1] from wdata[15:0].
  - SW writes all four lanes.
  - Unaddressed bytes are unchanged.
- Loads:
  - Extract the addressed byte/half.
  - B/H sign-extend; BU/HU zero-extend.
- Misaligned access: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - Store is suppressed; load returns 0.
  - misaligned_err = 1 during DONE only.
- mem_rdata_mem is registered and updated only on load completion. It holds its value through stores and idle cycles.
- Reset values:
  - State IDLE, cnt 0.
  - mem_rdata_mem 0, misaligned_err 0.
  - stall_pipl 0 unless IDLE & req.
- Reset mid-operation: returns to IDLE, any pending store is dropped, and rdata is cleared. Array contents are not reset.
- No reads-during-write hazard exists, because only one access is in flight at a time.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds two outputs, rd_cnt[31:0] and wr_cnt[31:0].
  - Both reset to 0.
  - Each increments by 1 in DONE for a completed, non-misaligned load/store.
  - Both wrap at 2^32.
- Undefined: the ports and the counters are absent; all other behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - mem_op_t enum: MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU.
  - dmem_state_t: IDLE, WAIT, DONE.
  - MAX_WAIT_STATES = 15 constant.
- Sub-module dmem_lane_align, purely combinational:
  - Store side: produces byte-enable[3:0] and a lane-shifted write word.
  - Load side: extracts and extends the load word.
  - Flags misalignment.
- Top level holds the FSM, the counter, the array and the rdata register.

Test Plan:
- SW 0x10 = 0xDEADBEEF, WAIT_STATES = 1 -> stall_pipl high for exactly 3 cycles, low in DONE. A following LW 0x10 returns 0xDEADBEEF in its DONE cycle.
- SB 0x13 = 0x000000A5 -> LW 0x10 = 0xA5ADBEEF; LB 0x13 = 0xFFFFFFA5; LBU 0x13 = 0x000000A5.
- SH 0x12 = 0x00001234 -> LW 0x10 = 0x1234BEEF; LH 0x10 = 0xFFFFBEEF; LHU 0x10 = 0x0000BEEF; LH 0x12 = 0x00001234.
- LW 0x11 -> misaligned_err pulses for 1 cycle and rdata = 0. SW 0x11 = 0xFFFFFFFF -> LW 0x10 is unchanged (0x1234BEEF).
- SW 0x20 = 0x55 with reset asserted in WAIT -> stall_pipl low the next cycle. LW 0x20 returns the prior contents (store dropped).
- DMEM_DEPTH = 1024: SW 0x1000 = 0x77 -> LW 0x0 = 0x77 (wrap). With DMEM_PERF_CNT_EN, after this sequence wr_cnt = 1 and rd_cnt = 1 (counters reset before the sequence).
